// File: rtl/mp_add_pkg.sv
// Shared definitions for the multi-precision add/subtract sequencer.
// Optional subtract support is enabled by defining MP_ADD_SUB_EN (see mp_add_seq).
package mp_add_pkg;

    localparam int unsigned WORD_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

endpackage

// File: rtl/rca16.sv
// 16-bit ripple-carry adder slice; the only adder in the sequencer datapath.
module rca16
    import mp_add_pkg::*;
(
    input  logic [WORD_W-1:0] i_a,
    input  logic [WORD_W-1:0] i_b,
    input  logic              i_cin,
    output logic [WORD_W-1:0] o_sum,
    output logic              o_cout
);

    logic w_carry;

    // Ripple the carry bit by bit from LSB to MSB
    always_comb begin
        o_sum   = '0;
        w_carry = i_cin;
        for (int i = 0; i < int'(WORD_W); i++) begin
            o_sum[i] = i_a[i] ^ i_b[i] ^ w_carry;
            w_carry  = (i_a[i] & i_b[i]) | (w_carry & (i_a[i] ^ i_b[i]));
        end
        o_cout = w_carry;
    end

endmodule

// File: rtl/mp_add_seq.sv
// Multi-precision add/subtract sequencer: one 16-bit word per cycle, LSW first,
// through a single rca16 slice with the carry chained across cycles.
// Define MP_ADD_SUB_EN to honour i_sub (A-B); otherwise i_sub is ignored (add only).
module mp_add_seq
    import mp_add_pkg::*;
#(
    parameter int unsigned WORDS = 4
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_start,
    input  logic                      i_sub,
    input  logic [WORD_W*WORDS-1:0]   i_op_a,
    input  logic [WORD_W*WORDS-1:0]   i_op_b,
    output logic                      o_busy,
    output logic                      o_done,
    output logic [WORD_W*WORDS-1:0]   o_result,
    output logic                      o_cout,
    output logic                      o_ovfl
);

    localparam int unsigned IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    state_t                         r_state;
    state_t                         w_state_d;
    logic                           w_accept;
    logic                           w_last;
    logic                           w_sub_in;

    logic [WORDS-1:0][WORD_W-1:0]   r_a;
    logic [WORDS-1:0][WORD_W-1:0]   r_b;
    logic [WORDS-1:0][WORD_W-1:0]   r_result;
    logic                           r_sub;
    logic [IDX_W-1:0]               r_idx;
    logic                           r_carry;
    logic                           r_cout;
    logic                           r_ovfl;
    logic                           r_done;

    logic [WORD_W-1:0]              w_a_word;
    logic [WORD_W-1:0]              w_b_eff;
    logic [WORD_W-1:0]              w_sum;
    logic                           w_slice_cout;

`ifdef MP_ADD_SUB_EN
    assign w_sub_in = i_sub;
`else
    logic w_unused_sub;
    assign w_unused_sub = i_sub;
    assign w_sub_in     = 1'b0;
`endif

    assign w_last   = (r_idx == LAST_IDX);
    assign w_a_word = r_a[r_idx];
    // Subtraction feeds the inverted B word; the +1 comes from the initial carry
    assign w_b_eff  = r_b[r_idx] ^ {WORD_W{r_sub}};

    rca16 u_slice (
        .i_a    (w_a_word),
        .i_b    (w_b_eff),
        .i_cin  (r_carry),
        .o_sum  (w_sum),
        .o_cout (w_slice_cout)
    );

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_d;
        end
    end

    // Next-state decode; start is only accepted from IDLE or DONE
    always_comb begin
        w_state_d = r_state;
        w_accept  = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_accept  = 1'b1;
                    w_state_d = RUN;
                end
            end
            RUN: begin
                if (w_last) begin
                    w_state_d = DONE;
                end
            end
            DONE: begin
                if (i_start) begin
                    w_accept  = 1'b1;
                    w_state_d = RUN;
                end else begin
                    w_state_d = IDLE;
                end
            end
            default: w_state_d = IDLE;
        endcase
    end

    // Operand capture and word-serial datapath
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_sub    <= 1'b0;
            r_idx    <= '0;
            r_carry  <= 1'b0;
            r_result <= '0;
            r_cout   <= 1'b0;
            r_ovfl   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_a      <= i_op_a;
                r_b      <= i_op_b;
                r_sub    <= w_sub_in;
                r_idx    <= '0;
                r_carry  <= w_sub_in;
                r_result <= '0;
            end else if (r_state == RUN) begin
                r_result[r_idx] <= w_sum;
                r_carry         <= w_slice_cout;
                if (w_last) begin
                    r_cout <= w_slice_cout;
                    // Signed overflow: operands agree in sign, sum sign differs
                    r_ovfl <= (w_a_word[WORD_W-1] == w_b_eff[WORD_W-1]) &&
                              (w_sum[WORD_W-1] != w_a_word[WORD_W-1]);
                    r_done <= 1'b1;
                end else begin
                    r_idx <= r_idx + IDX_W'(1);
                end
            end
        end
    end

    assign o_busy   = (r_state == RUN);
    assign o_done   = r_done;
    assign o_result = r_result;
    assign o_cout   = r_cout;
    assign o_ovfl   = r_ovfl;

endmodule
